// File: rtl/avg_accum_pkg.sv
// Shared window constants for the window generator and the averaging accumulator,
// so both stages agree on the window length NP.
package avg_accum_pkg;

    localparam int unsigned m     = 4;          // log2 of samples per window
    localparam int unsigned m_X   = 8;          // sample width
    localparam int unsigned NP    = 1 << m;
    localparam int unsigned ACC_W = m_X + m;    // NP full-scale samples fit without wrap
    localparam int unsigned CNT_W = m + 2;      // counts 0..NP+1

    typedef enum logic [1:0] {
        StWait,
        StIdle,
        StAcc
    } state_e;

endpackage

// File: rtl/avg_accum_if.sv
// Sample stream in, window result out, for the averaging accumulator.
interface avg_accum_if;
    import avg_accum_pkg::*;

    logic             ce;
    logic             tm;
    logic [m_X-1:0]   x;
    logic [ACC_W-1:0] sum;
    logic [m_X-1:0]   y;
    logic             rdy;
    logic             busy;
    logic             err;

    modport master (output ce, tm, x, input sum, y, rdy, busy, err);
    modport slave  (input ce, tm, x, output sum, y, rdy, busy, err);

endinterface

// File: rtl/avg_accum.sv
// Sums the samples of one measurement window and publishes sum, average and a
// length-error flag when the window closes.
module avg_accum
    import avg_accum_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    avg_accum_if.slave  bus
);

    state_e           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StWait;
            acc      <= '0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.y    <= '0;
            bus.err  <= 1'b0;
            bus.rdy  <= 1'b0;
        end else begin
            bus.rdy <= 1'b0;
            if (bus.ce) begin
                unique case (state)
                    // Tm may already be high after reset; only a fresh rising window counts.
                    StWait: begin
                        if (!bus.tm) state <= StIdle;
                    end
                    StIdle: begin
                        if (bus.tm) begin
                            state <= StAcc;
                            acc   <= ACC_W'(bus.x);
                            cnt   <= CNT_W'(1);
                        end
                    end
                    StAcc: begin
                        if (bus.tm) begin
                            if (cnt < CNT_W'(NP)) begin
                                acc <= acc + ACC_W'(bus.x);
                                cnt <= cnt + CNT_W'(1);
                            end else begin
                                cnt <= CNT_W'(NP + 1);
                            end
                        end else begin
                            state   <= StIdle;
                            bus.sum <= acc;
                            bus.y   <= acc[m_X+m-1:m];
                            bus.err <= (cnt != CNT_W'(NP));
                            bus.rdy <= 1'b1;
                        end
                    end
                    default: state <= StWait;
                endcase
            end
        end
    end

    assign bus.busy = (state == StAcc);

endmodule

// File: tb/tb_avg_accum.sv
// Directed and random windows for avg_accum, checked against a queue-based window model.
module tb_avg_accum;
    import avg_accum_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    avg_accum_if bus ();

    avg_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: a window is the list of samples seen while Tm is high after being armed.
    bit armed;
    bit in_win;
    int q[$];
    int exp_sum;
    int exp_y;
    int exp_err;
    int exp_rdy;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        armed   = 0;
        in_win  = 0;
        q.delete();
        exp_sum = 0;
        exp_y   = 0;
        exp_err = 0;
        exp_rdy = 0;
    endtask

    task automatic model_tick(input bit tm_v, input int x_v);
        int s;
        exp_rdy = 0;
        if (!armed) begin
            if (!tm_v) armed = 1;
        end else if (!in_win) begin
            if (tm_v) begin
                in_win = 1;
                q = {x_v};
            end
        end else if (tm_v) begin
            q.push_back(x_v);
        end else begin
            s = 0;
            for (int i = 0; i < q.size() && i < int'(NP); i++) s += q[i];
            exp_sum = s;
            exp_y   = s / int'(NP);
            exp_err = (q.size() != int'(NP)) ? 1 : 0;
            exp_rdy = 1;
            in_win  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdy"}, int'(bus.rdy), exp_rdy);
        chk({tag, ".busy"}, int'(bus.busy), int'(in_win));
        chk({tag, ".sum"}, int'(bus.sum), exp_sum);
        chk({tag, ".y"}, int'(bus.y), exp_y);
        chk({tag, ".err"}, int'(bus.err), exp_err);
    endtask

    // One ce tick preceded by gap clocks with ce low and X wandering.
    task automatic tick(input bit tm_v, input int x_v, input int gap, input string tag);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.ce = 1'b0;
            bus.x  = m_X'($urandom);
            chk({tag, ".rdy_gap"}, int'(bus.rdy), 0);
        end
        @(negedge clk);
        bus.ce = 1'b1;
        bus.tm = tm_v;
        bus.x  = m_X'(x_v);
        @(negedge clk);
        bus.ce = 1'b0;
        model_tick(tm_v, x_v);
        check_all(tag);
    endtask

    // kind: 0 constant val, 1 ramp from 0, 2 random. gap_at inserts a 50-clk ce-low stretch.
    task automatic window(input int n, input int kind, input int val, input int gap_at,
                          input string tag);
        int xv;
        for (int i = 0; i < n; i++) begin
            xv = (kind == 0) ? val : (kind == 1) ? i : int'($urandom_range(0, 255));
            tick(1'b1, xv, (i == gap_at) ? 50 : 3, tag);
        end
        tick(1'b0, int'($urandom_range(0, 255)), 3, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_state"}, {int'(bus.sum), int'(bus.rdy), int'(bus.busy), int'(bus.err)} == 0
            ? 0 : 1, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.ce = 1'b0;
        bus.tm = 1'b0;
        bus.x  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset.sum", int'(bus.sum), 0);
        chk("reset.y", int'(bus.y), 0);
        chk("reset.rdy", int'(bus.rdy), 0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.err", int'(bus.err), 0);
        rst = 1'b0;

        tick(1'b0, 0, 3, "arm");

        window(16, 0, 100, -1, "const100");
        chk("const100.sum_abs", int'(bus.sum), 1600);
        chk("const100.y_abs", int'(bus.y), 100);

        window(16, 1, 0, -1, "ramp");
        chk("ramp.sum_abs", int'(bus.sum), 120);
        chk("ramp.y_abs", int'(bus.y), 7);

        window(16, 0, 255, -1, "max");
        chk("max.sum_abs", int'(bus.sum), 4080);
        window(16, 0, 1, -1, "ones");
        chk("ones.sum_abs", int'(bus.sum), 16);

        window(10, 0, 32, -1, "short");
        chk("short.sum_abs", int'(bus.sum), 320);
        chk("short.err_abs", int'(bus.err), 1);
        window(20, 0, 32, -1, "long");
        chk("long.sum_abs", int'(bus.sum), 512);
        chk("long.err_abs", int'(bus.err), 1);

        // Reset mid-window with Tm held high: window is dropped, no rdy.
        do_reset("pre");
        tick(1'b0, 0, 3, "pre_arm");
        for (int i = 0; i < 8; i++) tick(1'b1, 50, 3, "abort");
        do_reset("abort");
        for (int i = 0; i < 8; i++) tick(1'b1, 50, 3, "abort_tail");
        tick(1'b0, 0, 3, "abort_tail");
        chk("abort.sum_abs", int'(bus.sum), 0);
        window(16, 0, 50, -1, "after_abort");
        chk("after_abort.y_abs", int'(bus.y), 50);
        chk("after_abort.err_abs", int'(bus.err), 0);

        window(16, 1, 0, 7, "gated");
        chk("gated.sum_abs", int'(bus.sum), 120);

        for (int w = 0; w < 20; w++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 22)) : 16;
            window(len, 2, 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                   "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avg_accum.md
AVG_ACCUM -- requirements
Module: avg_accum

Interface
REQ-001 Parameter/constant `m`: default 4; log2 of samples per measurement window (NP = 2^m).
REQ-002 Parameter/constant `m_X`: default 8; width of input sample X (unsigned).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ce  input  1  sample-rate clock enable; Tm and X are sampled only when ce=1.
REQ-006 Tm  input  1  measurement window from the upstream window generator; high for NP ce ticks per window.
REQ-007 X  input  m_X  unsigned sample to accumulate.
REQ-008 SUM  output  m_X+m  accumulated sum of the last completed window.
REQ-009 Y  output  m_X  average of the last completed window, SUM truncated: SUM[m_X+m-1:m].
REQ-010 rdy  output  1  one-clk pulse: SUM/Y/err just updated.
REQ-011 busy  output  1  high while state = ACC.
REQ-012 err  output  1  last completed window did not contain exactly NP samples.

Function
REQ-013 FSM states: WAIT (armed after reset, waiting for Tm low), IDLE (armed), ACC (accumulating).
REQ-014 All transitions occur only on clk edges with ce=1; with ce=0, state, accumulator, counter and outputs other than rdy hold.
REQ-015 WAIT -> IDLE when ce=1 and Tm=0; samples while in WAIT are discarded.
REQ-016 IDLE -> ACC when ce=1 and Tm=1; internal accumulator acc <= X, sample counter cnt <= 1.
REQ-017 In ACC, ce=1 and Tm=1: if cnt < NP then acc <= acc + X and cnt <= cnt + 1; else sample ignored and cnt saturates at NP+1 (overlong flag).
REQ-018 In ACC, ce=1 and Tm=0: go to IDLE; SUM <= acc, Y <= acc[m_X+m-1:m], err <= (cnt != NP), rdy <= 1.
REQ-019 rdy is high for exactly one clk cycle, the cycle after the closing edge of REQ-018; zero in all other cycles.
REQ-020 Latency: Y/SUM/err valid and rdy asserted one clk after the first ce edge that samples Tm=0 in ACC.
REQ-021 acc width m_X+m; NP samples of max value (2^m_X - 1) never overflow; no wrap permitted.
REQ-022 cnt width m+2 bits; counts 0..NP+1.
REQ-023 SUM, Y, err hold their values between rdy pulses.
REQ-024 Short window (cnt < NP): results still published, err=1.
REQ-025 Long window (Tm high > NP ticks): only first NP samples summed, err=1.
REQ-026 Back-to-back windows (Tm low for one ce tick): IDLE -> ACC on next ce tick with Tm=1; no sample lost.

Reset
REQ-027 rst=1 asynchronously forces state=WAIT, acc=0, cnt=0, SUM=0, Y=0, rdy=0, busy=0, err=0.
REQ-028 Reset during ACC aborts the window; no rdy pulse is produced for it, and the partial window is not resumed.
REQ-029 After rst release with Tm already high, accumulation starts only after Tm is seen low then high again.

Structure
REQ-030 `m` and `m_X` live in the shared constants header CONST_XY.v alongside the window generator's constants, so both stages agree on NP.
REQ-031 Single flat module; no sub-module is natural; FSM encoding is local to the module.

Verification (m=4, m_X=8, NP=16, ce every 4th clk)
REQ-032 X=100 constant, Tm high 16 ticks -> SUM=1600, Y=100, err=0, one rdy pulse one clk after the Tm-low tick.
REQ-033 X=0,1,...,15 over a 16-tick window -> SUM=120, Y=7, err=0.
REQ-034 X=255 for 16 ticks -> SUM=4080, Y=255, no wrap; follow-up window with X=1 gives SUM=16, Y=1.
REQ-035 Tm high for 10 ticks, X=32 -> SUM=320, Y=20, err=1. Tm high for 20 ticks, X=32 -> SUM=512, Y=32, err=1.
REQ-036 rst pulse at sample 8 of a window, Tm kept high -> no rdy and outputs stay 0; next full window with X=50 -> Y=50, err=0.
REQ-037 ce held low for 50 clk mid-window with X toggling -> results identical to the ungated run; rdy never wider than 1 clk.
